// File: rtl/uart_pkg.sv
// Shared types and constants for the buffered UART transmitter.
// FSM state encoding plus frame-format constants.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic UART_IDLE_LEVEL = 1'b1;
  localparam int   DATA_BITS       = 8;
  localparam int   MIN_DIV         = 2;

endpackage

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding the UART shifter.
// Show-ahead read port, registered full/empty flags.
module uart_tx_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [7:0]             din,
  input  logic                   pop,
  output logic [7:0]             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d;
  logic [AW-1:0] rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          do_push, do_pop;

  // pointer/count update; a push while full is dropped
  always_comb begin
    do_push = push & ~full_q;
    do_pop  = pop & ~empty_q;
    wr_d    = wr_q + AW'(do_push);
    rd_d    = rd_q + AW'(do_pop);
    cnt_d   = cnt_q + (AW+1)'(do_push)
                    - (AW+1)'(do_pop);
    full_d  = (cnt_d == (AW+1)'(DEPTH));
    empty_d = (cnt_d == '0);
  end

  // storage array, no reset needed
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= din;
  end

  // pointer and flag registers
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign dout  = mem_q[rd_q];
  assign full  = full_q;
  assign empty = empty_q;
  assign level = cnt_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter with programmable bit period.
// Define UART_TX_PARITY_EN for 8E1 frames (extra even-parity bit).
module uart_tx_buffered
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int DEFAULT_DIV = 106,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        reg_div_we,
  input  logic [DIV_WIDTH-1:0]        reg_div_di,
  output logic [DIV_WIDTH-1:0]        reg_div_do,
  input  logic                        reg_dat_we,
  input  logic [7:0]                  reg_dat_di,
  output logic                        reg_dat_wait,
  output logic [$clog2(FIFO_DEPTH):0] tx_level,
  output logic                        tx_busy,
  output logic                        ser_tx
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  tx_state_e            state_q, state_d;
  logic [DIV_WIDTH-1:0] div_q, div_d;
  logic [DIV_WIDTH-1:0] dlat_q, dlat_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [7:0]           shift_q, shift_d;
  logic [2:0]           bit_q, bit_d;
  logic                 ser_q, ser_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic [DIV_WIDTH-1:0] eff_div;
  logic                 start_frame;
  logic                 fifo_pop;
  logic [7:0]           fifo_dout;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [LW-1:0]        fifo_level;

  uart_tx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .resetn(resetn),
    .push  (reg_dat_we),
    .din   (reg_dat_di),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign eff_div = (div_q < DIV_WIDTH'(MIN_DIV))
                 ? DIV_WIDTH'(MIN_DIV) : div_q;

  // next-state, counter and line-level logic
  always_comb begin
    state_d     = state_q;
    div_d       = reg_div_we ? reg_div_di : div_q;
    dlat_d      = dlat_q;
    cnt_d       = cnt_q;
    shift_d     = shift_q;
    bit_d       = bit_q;
    ser_d       = UART_IDLE_LEVEL;
    start_frame = 1'b0;
    fifo_pop    = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_d       = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        start_frame = ~fifo_empty;
      end
      START: begin
        ser_d = 1'b0;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = dlat_q - 1'b1;
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        ser_d = shift_q[0];
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = dlat_q - 1'b1;
          shift_d = shift_q >> 1;
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'(DATA_BITS-1)) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        ser_d = par_q;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d   = dlat_q - 1'b1;
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          state_d     = IDLE;
          start_frame = ~fifo_empty;
        end
      end
      default: state_d = IDLE;
    endcase
    // divider is sampled once per frame here
    if (start_frame) begin
      fifo_pop = 1'b1;
      shift_d  = fifo_dout;
      dlat_d   = eff_div;
      cnt_d    = eff_div - 1'b1;
      state_d  = START;
`ifdef UART_TX_PARITY_EN
      par_d    = ^fifo_dout;
`endif
    end
  end

  // state registers; ser_tx is a flop so the pad never glitches
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      div_q   <= DIV_WIDTH'(DEFAULT_DIV);
      dlat_q  <= DIV_WIDTH'(DEFAULT_DIV);
      cnt_q   <= '0;
      shift_q <= '0;
      bit_q   <= '0;
      ser_q   <= UART_IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      dlat_q  <= dlat_d;
      cnt_q   <= cnt_d;
      shift_q <= shift_d;
      bit_q   <= bit_d;
      ser_q   <= ser_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  assign reg_div_do   = div_q;
  assign reg_dat_wait = fifo_full;
  assign tx_level     = fifo_level;
  assign tx_busy      = (state_q != IDLE)
                      | (fifo_level != '0);
  assign ser_tx       = ser_q;

endmodule

// File: tb/tb_uart_tx_buffered.sv
// Scoreboard bench for uart_tx_buffered (default 8N1 build).
// Serial monitor decodes frames and checks every cycle of each frame.
module tb_uart_tx_buffered;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        reg_div_we = 1'b0;
  logic [15:0] reg_div_di = '0;
  logic [15:0] reg_div_do;
  logic        reg_dat_we = 1'b0;
  logic [7:0]  reg_dat_di = '0;
  logic        reg_dat_wait;
  logic [3:0]  tx_level;
  logic        tx_busy;
  logic        ser_tx;

  uart_tx_buffered #(
    .FIFO_DEPTH (8),
    .DEFAULT_DIV(106),
    .DIV_WIDTH  (16)
  ) dut (
    .clk         (clk),
    .resetn      (rst_n),
    .reg_div_we  (reg_div_we),
    .reg_div_di  (reg_div_di),
    .reg_div_do  (reg_div_do),
    .reg_dat_we  (reg_dat_we),
    .reg_dat_di  (reg_dat_di),
    .reg_dat_wait(reg_dat_wait),
    .tx_level    (tx_level),
    .tx_busy     (tx_busy),
    .ser_tx      (ser_tx)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int bit_per = 106;
  logic [7:0] expq[$];
  int starts[$];

  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  // monitor: one frame, P cycles per bit, sampled at negedges
  task automatic run_frame();
    int p, errs, b;
    bit have;
    logic [7:0] eb, got;
    logic lvl;
    p = bit_per;
    starts.push_back(cyc);
    have = (expq.size() > 0);
    eb = have ? expq.pop_front() : 8'h00;
    got = '0;
    errs = 0;
    for (int i = 0; i < 10 * p; i++) begin
      if (i > 0) @(negedge clk);
      if (!rst_n) return;
      b = i / p;
      if (b == 0) lvl = 1'b0;
      else if (b == 9) lvl = 1'b1;
      else lvl = eb[b-1];
      if (ser_tx !== lvl) errs++;
      if (i % p == p / 2 && b >= 1 && b <= 8)
        got[b-1] = ser_tx;
    end
    chk("frame_expected", have, 1);
    chk("frame_data", got, eb);
    chk("frame_shape_errs", errs, 0);
  endtask

  initial begin : monitor
    logic prev;
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n && prev && !ser_tx) begin
        run_frame();
        prev = 1'b1;
      end else begin
        prev = ser_tx;
      end
    end
  end

  // called at a negedge, returns at the next negedge
  task automatic write_byte(input logic [7:0] b,
                            input bit ok);
    chk("dat_wait", reg_dat_wait, !ok);
    reg_dat_di = b;
    reg_dat_we = 1'b1;
    if (ok) expq.push_back(b);
    @(negedge clk);
    reg_dat_we = 1'b0;
  endtask

  task automatic write_div(input int d);
    reg_div_di = 16'(d);
    reg_div_we = 1'b1;
    @(negedge clk);
    reg_div_we = 1'b0;
    bit_per = (d < 2) ? 2 : d;
    chk("div_readback", reg_div_do, d);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (tx_busy && k < 20000) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout_busy", tx_busy, 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int n0, k, d, n;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_level", tx_level, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_wait", reg_dat_wait, 0);
    chk("rst_ser", ser_tx, 1);
    chk("rst_div", reg_div_do, 106);

    // single byte latency and busy window
    starts.delete();
    n0 = cyc;
    write_byte(8'h55, 1);
    chk("lvl_after_push", tx_level, 1);
    chk("busy_after_push", tx_busy, 1);
    @(negedge clk);
    chk("lvl_after_pop", tx_level, 0);
    chk("ser_n1", ser_tx, 1);
    @(negedge clk);
    chk("ser_n2", ser_tx, 0);
    while (cyc < n0 + 1061) @(negedge clk);
    chk("busy_late", tx_busy, 1);
    repeat (2) @(negedge clk);
    chk("busy_done", tx_busy, 0);
    chk("start_count1", starts.size(), 1);
    if (starts.size() > 0)
      chk("start_cycle", starts[0], n0 + 3);
    wait_idle();

    // burst of ten: ninth fills FIFO, tenth dropped
    starts.delete();
    for (int i = 0; i < 10; i++)
      write_byte(8'(i), i < 9);
    chk("lvl_full", tx_level, 8);
    chk("wait_full", reg_dat_wait, 1);
    wait_idle();
    chk("burst_frames", starts.size(), 9);
    for (int i = 1; i < starts.size(); i++)
      chk("burst_gap", starts[i] - starts[i-1], 1060);

    // divider change mid-frame
    starts.delete();
    write_byte(8'h41, 1);
    write_byte(8'h42, 1);
    repeat (300) @(negedge clk);
    write_div(10);
    wait_idle();
    chk("divchg_frames", starts.size(), 2);
    if (starts.size() == 2)
      chk("divchg_gap", starts[1] - starts[0], 1060);

    // divider clamped to minimum
    write_div(0);
    write_byte(8'hA5, 1);
    wait_idle();
    write_div(1);
    write_byte(8'hA5, 1);
    wait_idle();

    // randomized bursts
    for (int it = 0; it < 6; it++) begin
      d = $urandom_range(0, 20);
      write_div(d);
      n = $urandom_range(1, 8);
      for (int j = 0; j < n; j++)
        write_byte(8'($urandom_range(0, 255)), 1);
      wait_idle();
    end

    // async reset during a start bit
    write_div(10);
    write_byte(8'hFF, 1);
    write_byte(8'h11, 1);
    write_byte(8'h22, 1);
    k = 0;
    while (ser_tx && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("pre_rst_ser_low", ser_tx, 0);
    #2 rst_n = 1'b0;
    #1;
    chk("async_ser", ser_tx, 1);
    chk("async_level", tx_level, 0);
    chk("async_busy", tx_busy, 0);
    chk("async_wait", reg_dat_wait, 0);
    chk("async_div", reg_div_do, 106);
    expq.delete();
    bit_per = 106;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    write_byte(8'h3C, 1);
    wait_idle();

    chk("scoreboard_empty", expq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
